message_scan_display: RTL and testbench



---
 rtl/seg_display_pkg.sv | 20 ++
 rtl/char_to_seg.sv | 11 +
 rtl/message_scan_display.sv | 88 ++++++++
 tb/tb_message_scan_display.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants for the 7-segment display blocks: blanking patterns, hex font, default message.
package seg_display_pkg;

    localparam logic [6:0]  SEG_BLANK       = 7'b1111111;
    localparam logic [3:0]  AN_OFF          = 4'b1111;
    localparam logic [63:0] DEFAULT_MESSAGE = 64'hFEDCBA9876543210;

    // Active-low hex font, bits g..a; entry 0 is the least significant element.
    localparam logic [15:0][6:0] HEX_FONT = {
        7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
        7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
        7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
        7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
    };

    function automatic logic [3:0] message_char(input logic [63:0] msg, input logic [3:0] idx);
        return msg[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/char_to_seg.sv
// Combinational 4-bit to active-low 7-segment hex decoder.
module char_to_seg
    import seg_display_pkg::*;
(
    input  logic [3:0] code,
    output logic [6:0] seg_c
);

    assign seg_c = HEX_FONT[code];

endmodule

// File: rtl/message_scan_display.sv
// Scans a 4-character window of a fixed message onto a multiplexed common-anode display,
// rotating the window only at frame boundaries using a synchronised button count.
module message_scan_display
    import seg_display_pkg::*;
#(
    parameter int unsigned DIV_WIDTH    = 16,
    parameter int unsigned BLANK_CYCLES = 64,
    parameter logic [63:0] MESSAGE      = DEFAULT_MESSAGE
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] counter,
    output logic [3:0] an,
    output logic [6:0] seg
);

    localparam logic [DIV_WIDTH-1:0] BLANK_LIMIT = DIV_WIDTH'(BLANK_CYCLES);

    logic [3:0]           s1, s2, s3;
    logic [3:0]           offset;
    logic [DIV_WIDTH-1:0] slot_cnt;
    logic [1:0]           digit;

    logic                 slot_wrap_c;
    logic                 frame_end_c;
    logic                 blank_c;
    logic [3:0]           char_idx_c;
    logic [3:0]           char_c;
    logic [6:0]           seg_dec_c;
    logic [3:0]           an_sel_c;

    assign slot_wrap_c = (slot_cnt == '1);
    assign frame_end_c = slot_wrap_c && (digit == 2'd3);
    assign blank_c     = (slot_cnt < BLANK_LIMIT);
    assign char_idx_c  = offset + 4'(digit);
    assign char_c      = message_char(MESSAGE, char_idx_c);
    assign an_sel_c    = ~(4'b1000 >> digit);

    char_to_seg u_char_to_seg (
        .code  (char_c),
        .seg_c (seg_dec_c)
    );

    // Three-flop synchroniser; the offset only accepts a value that held for two cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1     <= 4'd0;
            s2     <= 4'd0;
            s3     <= 4'd0;
            offset <= 4'd0;
        end else begin
            s1 <= counter;
            s2 <= s1;
            s3 <= s2;
            if (frame_end_c && (s2 == s3)) begin
                offset <= s2;
            end
        end
    end

    // Slot and digit scan counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt <= '0;
            digit    <= 2'd0;
        end else begin
            slot_cnt <= slot_cnt + DIV_WIDTH'(1);
            if (slot_wrap_c) begin
                digit <= digit + 2'd1;
            end
        end
    end

    // Registered pin drivers, blanked at the start of every slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else if (blank_c) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_sel_c;
            seg <= seg_dec_c;
        end
    end

endmodule

// File: tb/tb_message_scan_display.sv
// Directed bench for message_scan_display with a cycle-indexed reference model.
module tb_message_scan_display;

    localparam int SLOT  = 8;
    localparam int FRAME = 32;
    localparam int BC    = 1;
    localparam logic [63:0] MSG = 64'hFEDCBA9876543210;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] counter;
    logic [3:0] an;
    logic [6:0] seg;

    always #5 clk = ~clk;

    message_scan_display #(
        .DIV_WIDTH    (3),
        .BLANK_CYCLES (1),
        .MESSAGE      (MSG)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .counter (counter),
        .an      (an),
        .seg     (seg)
    );

    function automatic logic [6:0] font_of(input int v);
        case (v)
            0:  return 7'b1000000;  1:  return 7'b1111001;
            2:  return 7'b0100100;  3:  return 7'b0110000;
            4:  return 7'b0011001;  5:  return 7'b0010010;
            6:  return 7'b0000010;  7:  return 7'b1111000;
            8:  return 7'b0000000;  9:  return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    // Reference: position k since reset release fixes slot and digit; the offset
    // is the counter sample history checked at each frame's last edge.
    int         k;
    int         off;
    logic [3:0] samp [0:1023];
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int         m_slot;
    int         m_d;
    logic [3:0] m_an;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k       <= 0;
            off     <= 0;
            exp_an  <= 4'hF;
            exp_seg <= 7'h7F;
        end else begin
            m_slot = k % SLOT;
            m_d    = (k / SLOT) % 4;
            if (k < 1024) samp[k] <= counter;
            if (m_slot < BC) begin
                exp_an  <= 4'hF;
                exp_seg <= 7'h7F;
            end else begin
                m_an         = 4'hF;
                m_an[3-m_d]  = 1'b0;
                exp_an  <= m_an;
                exp_seg <= font_of(int'((MSG >> (4 * ((off + m_d) % 16))) & 64'hF));
            end
            if ((k % FRAME == FRAME - 1) && (samp[k-2] == samp[k-3])) off <= int'(samp[k-2]);
            k <= k + 1;
        end
    end

    int         checks = 0;
    int         errors = 0;
    int         e_cnt  = 0;
    logic [3:0] prev_an  = 4'hF;
    logic [3:0] prev2_an = 4'hF;

    task automatic check_val(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t (E=%0d): got %0h, expected %0h", name, $time, e_cnt, act, req);
        end
    endtask

    task automatic lit(input string name, input logic [3:0] a, input logic [6:0] s);
        check_val({name, "_an"}, int'(an), int'(a));
        check_val({name, "_seg"}, int'(seg), int'(s));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (!reset) e_cnt++;
        check_val("model_an", int'(an), int'(exp_an));
        check_val("model_seg", int'(seg), int'(exp_seg));
        check_val("onehot_an", ($countones(~an) <= 1) ? 1 : 0, 1);
        if (!reset && e_cnt >= 3 && an != 4'hF && an != prev_an)
            check_val("single_blank", (prev_an == 4'hF && prev2_an != 4'hF) ? 1 : 0, 1);
        prev2_an = reset ? 4'hF : prev_an;
        prev_an  = reset ? 4'hF : an;
    endtask

    task automatic run_to(input int target);
        while (e_cnt < target) tick();
    endtask

    initial begin
        reset   = 1'b1;
        counter = 4'd0;
        repeat (3) tick();
        lit("in_reset", 4'b1111, 7'b1111111);
        reset = 1'b0;
        e_cnt = 0;

        // First frame after reset shows "0123".
        tick();
        lit("first_blank", 4'b1111, 7'b1111111);
        tick();
        lit("f0_d0", 4'b0111, 7'b1000000);
        run_to(10);  lit("f0_d1", 4'b1011, 7'b1111001);
        run_to(18);  lit("f0_d2", 4'b1101, 7'b0100100);
        run_to(26);  lit("f0_d3", 4'b1110, 7'b0110000);

        // Offset 14 wraps to "EF01".
        counter = 4'd14;
        run_to(34);  lit("ef01_e", 4'b0111, 7'b0000110);
        run_to(42);  lit("ef01_f", 4'b1011, 7'b0001110);
        run_to(50);  lit("ef01_0", 4'b1101, 7'b1000000);
        run_to(58);  lit("ef01_1", 4'b1110, 7'b1111001);

        // Back to 0, then change to 5 while digit 1 is lit.
        counter = 4'd0;
        run_to(74);
        counter = 4'd5;
        run_to(82);  lit("hold_2", 4'b1101, 7'b0100100);
        run_to(90);  lit("hold_3", 4'b1110, 7'b0110000);
        run_to(98);  lit("s5_5", 4'b0111, 7'b0010010);
        run_to(106); lit("s5_6", 4'b1011, 7'b0000010);
        run_to(114); lit("s5_7", 4'b1101, 7'b1111000);
        run_to(122); lit("s5_8", 4'b1110, 7'b0000000);

        // Unstable counter across a boundary keeps the old offset.
        repeat (10) begin
            counter = (counter == 4'd15) ? 4'd0 : 4'd15;
            tick();
        end
        counter = 4'd15;
        run_to(138); lit("toggle_keep", 4'b1011, 7'b0000010);
        run_to(162); lit("f012_f", 4'b0111, 7'b0001110);
        run_to(170); lit("f012_0", 4'b1011, 7'b1000000);
        run_to(178); lit("f012_1", 4'b1101, 7'b1111001);
        run_to(186); lit("f012_2", 4'b1110, 7'b0100100);

        // Offset 9, then asynchronous reset during digit 2.
        counter = 4'd9;
        run_to(211); lit("o9_d2", 4'b1101, 7'b0000011);
        #2;
        reset = 1'b1;
        #1;
        lit("async_blank", 4'b1111, 7'b1111111);
        repeat (2) tick();
        reset = 1'b0;
        e_cnt = 0;
        run_to(2);   lit("post_rst_d0", 4'b0111, 7'b1000000);
        run_to(26);  lit("post_rst_d3", 4'b1110, 7'b0110000);
        run_to(34);  lit("post_rst_o9", 4'b0111, 7'b0010000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
